// File: rtl/hazard_ctrl_id.sv
// hazard_ctrl_id: decode-stage hazard and stall controller.
// Detects load-use and branch-operand hazards against ID/EX, reacts to
// I-cache / D-cache busy and HLT, and drives PC / IF/ID / ID/EX control.
// Optional feature macro: HAZARD_STALL_CNT_EN adds a saturating 16-bit
// count of PC-stall cycles on the stall_cycles port.
module hazard_ctrl_id (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ID_src1,
  input  logic [3:0]  ID_src2,
  input  logic        ID_use1,
  input  logic        ID_use2,
  input  logic        ID_is_branch,
  input  logic        ID_br_taken,
  input  logic        ID_halt,
  input  logic [3:0]  IDEX_dst,
  input  logic        IDEX_RegWrite,
  input  logic        IDEX_MemRead,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  output logic        pc_wen,
  output logic        ifid_wen,
  output logic        ifid_flush,
  output logic        nop_idex,
  output logic        pipe_wen,
  output logic [1:0]  hz_state
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BR_STALL = 2'd1,
    ST_HALTED   = 2'd2,
    ST_UNUSED   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_br_cnt;
  logic [1:0]  w_next_br_cnt;
  logic        w_lu;
  logic        w_bh;

  // True when the ID/EX instruction writes register r (R0 is never a producer).
  function automatic logic dep(input logic [3:0] r, input logic [3:0] dst,
                               input logic wr);
    dep = wr & (dst != 4'd0) & (dst == r);
  endfunction

  assign w_lu = IDEX_MemRead &
                ((ID_use1 & dep(ID_src1, IDEX_dst, IDEX_RegWrite)) |
                 (ID_use2 & dep(ID_src2, IDEX_dst, IDEX_RegWrite)));
  assign w_bh = ID_is_branch & dep(ID_src1, IDEX_dst, IDEX_RegWrite);

  assign hz_state = r_state;

  // Priority decode of control outputs and next state, zero-latency from inputs.
  always_comb begin
    pc_wen        = 1'b1;
    ifid_wen      = 1'b1;
    ifid_flush    = 1'b0;
    nop_idex      = 1'b0;
    pipe_wen      = 1'b1;
    w_next_state  = r_state;
    w_next_br_cnt = r_br_cnt;
    if (!rst) begin
      pc_wen     = 1'b0;
      ifid_wen   = 1'b0;
      ifid_flush = 1'b1;
      nop_idex   = 1'b1;
      pipe_wen   = 1'b1;
    end else if (dmem_busy) begin
      // Whole pipeline freezes; state and branch-stall count hold.
      pc_wen   = 1'b0;
      ifid_wen = 1'b0;
      pipe_wen = 1'b0;
      nop_idex = 1'b0;
    end else begin
      case (r_state)
        ST_HALTED: begin
          pc_wen     = 1'b0;
          ifid_flush = 1'b1;
          nop_idex   = 1'b1;
        end
        ST_BR_STALL: begin
          pc_wen   = 1'b0;
          ifid_wen = 1'b0;
          nop_idex = 1'b1;
          if (r_br_cnt == 2'd0) begin
            w_next_state = ST_RUN;
          end else begin
            w_next_br_cnt = r_br_cnt - 2'd1;
          end
        end
        ST_RUN: begin
          if (w_lu | w_bh) begin
            pc_wen   = 1'b0;
            ifid_wen = 1'b0;
            nop_idex = 1'b1;
            // A branch reading a load result needs a second stall cycle.
            if (w_bh & IDEX_MemRead) begin
              w_next_state  = ST_BR_STALL;
              w_next_br_cnt = 2'd0;
            end else begin
              w_next_state = ST_RUN;
            end
          end else if (ID_br_taken) begin
            // Redirect wins over a pending I-cache miss.
            pc_wen     = 1'b1;
            ifid_flush = 1'b1;
          end else if (imem_busy) begin
            pc_wen     = 1'b0;
            ifid_flush = 1'b1;
          end else if (ID_halt) begin
            w_next_state = ST_HALTED;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        default: begin
          w_next_state  = ST_RUN;
          w_next_br_cnt = 2'd0;
        end
      endcase
    end
  end

  // State and branch-stall count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_br_cnt <= 2'd0;
    end else begin
      r_state  <= w_next_state;
      r_br_cnt <= w_next_br_cnt;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] r_stall_cycles;

  // Saturating count of PC-stall cycles outside HALTED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= 16'd0;
    end else if (!pc_wen && (r_state != ST_HALTED) &&
                 (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_ctrl_id.sv
// tb_hazard_ctrl_id: directed self-checking bench for hazard_ctrl_id.
// Expected output vectors are queued as stimulus is applied and popped
// at the following falling edge for comparison.
module tb_hazard_ctrl_id;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ID_src1, ID_src2, IDEX_dst;
  logic        ID_use1, ID_use2, ID_is_branch, ID_br_taken, ID_halt;
  logic        IDEX_RegWrite, IDEX_MemRead, imem_busy, dmem_busy;
  logic        pc_wen, ifid_wen, ifid_flush, nop_idex, pipe_wen;
  logic [1:0]  hz_state;
`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int          errors = 0;
  int          checks = 0;
  int          model_cnt = 0;
  logic [6:0]  exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  hazard_ctrl_id dut (
    .clk(clk), .rst(rst),
    .ID_src1(ID_src1), .ID_src2(ID_src2),
    .ID_use1(ID_use1), .ID_use2(ID_use2),
    .ID_is_branch(ID_is_branch), .ID_br_taken(ID_br_taken), .ID_halt(ID_halt),
    .IDEX_dst(IDEX_dst), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
    .nop_idex(nop_idex), .pipe_wen(pipe_wen), .hz_state(hz_state)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // {pc_wen, ifid_wen, ifid_flush, nop_idex, pipe_wen, hz_state}
  function automatic logic [6:0] mk(input logic pc, input logic iw, input logic fl,
                                    input logic nop, input logic pw,
                                    input logic [1:0] st);
    return {pc, iw, fl, nop, pw, st};
  endfunction

  task automatic clr();
    ID_src1 = 4'd0; ID_src2 = 4'd0; ID_use1 = 1'b0; ID_use2 = 1'b0;
    ID_is_branch = 1'b0; ID_br_taken = 1'b0; ID_halt = 1'b0;
    IDEX_dst = 4'd0; IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0;
    imem_busy = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic load_in_idex(input logic [3:0] dst);
    IDEX_dst = dst; IDEX_RegWrite = 1'b1; IDEX_MemRead = 1'b1;
  endtask

  // Queue the expectation, compare at the falling edge, return just after the rising edge.
  task automatic check_cycle(input string tag, input logic [6:0] exp);
    logic [6:0] got;
    logic [6:0] e;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    got = {pc_wen, ifid_wen, ifid_flush, nop_idex, pipe_wen, hz_state};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", t, got, e);
    end
`ifdef HAZARD_STALL_CNT_EN
    checks++;
    assert (stall_cycles === model_cnt[15:0]) else begin
      errors++;
      $error("FAIL %s_cnt: observed=%0d expected=%0d", t, stall_cycles, model_cnt);
    end
`endif
    if (rst && !e[6] && (e[1:0] != 2'd2)) model_cnt++;
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] DEF   = 7'b1100100;
  localparam logic [6:0] RSTV  = 7'b0011100;

  initial begin
    clr();
    rst = 1'b0;
    check_cycle("reset", RSTV);
    rst = 1'b1;
    check_cycle("idle", DEF);

    // Load-use on src2.
    load_in_idex(4'd3); ID_use2 = 1'b1; ID_src2 = 4'd3;
    check_cycle("lu_stall", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
    clr(); ID_use2 = 1'b1; ID_src2 = 4'd3;
    check_cycle("lu_after", DEF);
    // R0 never hazards; unused operand never hazards.
    load_in_idex(4'd0); ID_use2 = 1'b1; ID_src2 = 4'd0;
    check_cycle("lu_r0", DEF);
    load_in_idex(4'd3); ID_use2 = 1'b0; ID_src2 = 4'd3;
    check_cycle("lu_unused", DEF);
    clr();

    // Branch on a load: 0,1,0.
    load_in_idex(4'd5); ID_is_branch = 1'b1; ID_src1 = 4'd5;
    check_cycle("bh_load_c1", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
    IDEX_dst = 4'd0; IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0;
    check_cycle("bh_load_c2", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1));
    check_cycle("bh_load_done", DEF);
    clr();

    // Branch on an ALU result: single stall.
    IDEX_dst = 4'd5; IDEX_RegWrite = 1'b1; ID_is_branch = 1'b1; ID_src1 = 4'd5;
    check_cycle("bh_alu", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
    IDEX_dst = 4'd0; IDEX_RegWrite = 1'b0;
    check_cycle("bh_alu_done", DEF);
    clr();

    // D-cache miss during BR_STALL freezes it; one stall cycle remains.
    load_in_idex(4'd7); ID_is_branch = 1'b1; ID_src1 = 4'd7;
    check_cycle("frz_enter", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
    IDEX_dst = 4'd0; IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0; dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_cycle("frz_hold", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
    end
    dmem_busy = 1'b0;
    check_cycle("frz_resume", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1));
    check_cycle("frz_done", DEF);
    clr();

    // D-cache miss beats a taken branch in RUN.
    dmem_busy = 1'b1; ID_br_taken = 1'b1;
    check_cycle("dmem_prio", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    clr();

    // LU and BH together on a load: two stall cycles.
    load_in_idex(4'd4); ID_is_branch = 1'b1; ID_src1 = 4'd4; ID_use2 = 1'b1; ID_src2 = 4'd4;
    check_cycle("lubh_c1", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
    IDEX_dst = 4'd0; IDEX_RegWrite = 1'b0; IDEX_MemRead = 1'b0;
    check_cycle("lubh_c2", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1));
    check_cycle("lubh_done", DEF);
    clr();

    // Redirect and fetch bubble.
    ID_br_taken = 1'b1; imem_busy = 1'b1;
    check_cycle("taken_imiss", mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0));
    ID_br_taken = 1'b0;
    check_cycle("imiss", mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0));
    ID_br_taken = 1'b1; imem_busy = 1'b0;
    check_cycle("taken", mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0));
    clr();

    // Async reset from BR_STALL.
    load_in_idex(4'd6); ID_is_branch = 1'b1; ID_src1 = 4'd6;
    check_cycle("rbr_enter", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
    clr();
    rst = 1'b0;
    model_cnt = 0;
    #1;
    checks++;
    assert (hz_state === 2'd0) else begin
      errors++;
      $error("FAIL rst_from_br: observed=%0d expected=0", hz_state);
    end
    check_cycle("rst_br_hold", RSTV);
    rst = 1'b1;
    check_cycle("rst_br_after", DEF);

    // Halt: HLT passes in RUN, then HALTED persists until reset.
    ID_halt = 1'b1;
    check_cycle("halt_enter", DEF);
    clr();
    ID_br_taken = 1'b1;
    for (int i = 0; i < 11; i++) begin
      check_cycle("halted", mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2));
    end
    clr();
    rst = 1'b0;
    model_cnt = 0;
    #1;
    checks++;
    assert (hz_state === 2'd0) else begin
      errors++;
      $error("FAIL rst_from_halt: observed=%0d expected=0", hz_state);
    end
    check_cycle("rst_halt_hold", RSTV);
    rst = 1'b1;
    check_cycle("rst_halt_after", DEF);

    // Three load-use stalls plus four D-cache freeze cycles.
    for (int i = 0; i < 3; i++) begin
      load_in_idex(4'd2); ID_use1 = 1'b1; ID_src1 = 4'd2;
      check_cycle("cnt_lu", mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0));
      clr();
    end
    dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_cycle("cnt_dmem", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    end
    clr();
    check_cycle("cnt_final", DEF);
`ifdef HAZARD_STALL_CNT_EN
    checks++;
    assert (stall_cycles === 16'd7) else begin
      errors++;
      $error("FAIL cnt_seven: observed=%0d expected=7", stall_cycles);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
